// File: rtl/knowles_pkg.sv
// Shared helpers for the pipelined Knowles adder: level count and the
// single-bit prefix cell equations used by every tree level.
package knowles_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Black cell: combine a higher (h) group with the adjacent lower (l) group.
  function automatic logic black_g(input logic gh, input logic ph, input logic gl);
    return gh | (ph & gl);
  endfunction

  function automatic logic black_p(input logic ph, input logic pl);
    return ph & pl;
  endfunction

  // Grey cell: the lower group already reaches the carry-in, so only G matters.
  function automatic logic grey_g(input logic gh, input logic ph, input logic gl);
    return gh | (ph & gl);
  endfunction

endpackage

// File: rtl/knowles_prefix_level.sv
// One Knowles prefix level (span DIST) with an optional valid/ready register
// slice behind it. Bit 0 already carries the folded carry-in.
module knowles_prefix_level
  import knowles_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int DIST  = 1,
  parameter bit REG   = 1'b0,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_g,
  input  logic [WIDTH-1:0] up_p,
  input  logic [WIDTH-1:0] up_po,
  input  logic             up_ci,
  input  logic [TAG_W-1:0] up_tag,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_g,
  output logic [WIDTH-1:0] dn_p,
  output logic [WIDTH-1:0] dn_po,
  output logic             dn_ci,
  output logic [TAG_W-1:0] dn_tag
);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] po;
    logic             ci;
    logic [TAG_W-1:0] tag;
  } payload_t;

  payload_t nxt;

  // Node i whose lower partner (i-DIST) already spans down to bit -1 is a grey cell.
  always_comb begin
    nxt.g   = up_g;
    nxt.p   = up_p;
    nxt.po  = up_po;
    nxt.ci  = up_ci;
    nxt.tag = up_tag;
    for (int i = DIST; i < WIDTH; i++) begin
      if (i < 2 * DIST) begin
        nxt.g[i] = grey_g(up_g[i], up_p[i], up_g[i-DIST]);
        nxt.p[i] = 1'b0;
      end else begin
        nxt.g[i] = black_g(up_g[i], up_p[i], up_g[i-DIST]);
        nxt.p[i] = black_p(up_p[i], up_p[i-DIST]);
      end
    end
  end

  generate
    if (REG) begin : g_reg
      payload_t q;
      logic     v_q;

      // Handshake: a stage accepts when empty or when its content leaves this cycle.
      assign up_ready = !v_q || dn_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          q   <= '0;
        end else begin
          if (flush)         v_q <= 1'b0;
          else if (up_ready) v_q <= up_valid;
          if (up_ready)      q   <= nxt;
        end
      end

      assign dn_valid = v_q;
      assign dn_g     = q.g;
      assign dn_p     = q.p;
      assign dn_po    = q.po;
      assign dn_ci    = q.ci;
      assign dn_tag   = q.tag;
    end else begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, flush};

      assign up_ready = dn_ready;
      assign dn_valid = up_valid;
      assign dn_g     = nxt.g;
      assign dn_p     = nxt.p;
      assign dn_po    = nxt.po;
      assign dn_ci    = nxt.ci;
      assign dn_tag   = nxt.tag;
    end
  endgenerate

endmodule

// File: rtl/knowles_adder_pipe.sv
// Pipelined Knowles adder/subtractor: {cout,sum} = a + (b^{W{sub}}) + (cin^sub),
// with selectable register cuts in the prefix tree and full valid/ready backpressure.
module knowles_adder_pipe
  import knowles_pkg::*;
#(
  parameter int          WIDTH     = 28,
  parameter int unsigned PIPE_MASK = 5'b00100,
  parameter int          TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = clog2(WIDTH);

  logic [WIDTH-1:0] lg   [LEVELS+1];
  logic [WIDTH-1:0] lp   [LEVELS+1];
  logic [WIDTH-1:0] lpo  [LEVELS+1];
  logic             lci  [LEVELS+1];
  logic [TAG_W-1:0] ltag [LEVELS+1];
  logic             lv   [LEVELS+1];
  logic             lr   [LEVELS+1];

  logic [WIDTH-1:0] b_eff, g0, p0;
  logic             cin_eff;

  assign cin_eff = cin ^ sub;
  assign b_eff   = b ^ {WIDTH{sub}};
  assign g0      = a & b_eff;
  assign p0      = a ^ b_eff;

  // Bit -1 (the carry-in) is merged into bit 0 up front, so bit 0 is complete
  // and the tree only has to span WIDTH bits; its P is zero from here on.
  assign lg[0]   = {g0[WIDTH-1:1], grey_g(g0[0], p0[0], cin_eff)};
  assign lp[0]   = {p0[WIDTH-1:1], 1'b0};
  assign lpo[0]  = p0;
  assign lci[0]  = cin_eff;
  assign ltag[0] = in_tag;
  assign lv[0]   = in_valid;
  assign in_ready = lr[0];

  generate
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      knowles_prefix_level #(
        .WIDTH (WIDTH),
        .DIST  (1 << k),
        .REG   (((PIPE_MASK >> k) & 1) != 0),
        .TAG_W (TAG_W)
      ) u_level (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .up_valid (lv[k]),
        .up_ready (lr[k]),
        .up_g     (lg[k]),
        .up_p     (lp[k]),
        .up_po    (lpo[k]),
        .up_ci    (lci[k]),
        .up_tag   (ltag[k]),
        .dn_valid (lv[k+1]),
        .dn_ready (lr[k+1]),
        .dn_g     (lg[k+1]),
        .dn_p     (lp[k+1]),
        .dn_po    (lpo[k+1]),
        .dn_ci    (lci[k+1]),
        .dn_tag   (ltag[k+1])
      );
    end
  endgenerate

  logic unused_p;
  assign unused_p = ^lp[LEVELS];

  // After the tree, G[i] is the carry into bit i+1; the carry into bit 0 is cin_eff.
  logic [WIDTH-1:0] carries, sum_c;
  logic             cout_c, ovf_c;

  assign carries = {lg[LEVELS][WIDTH-2:0], lci[LEVELS]};
  assign sum_c   = lpo[LEVELS] ^ carries;
  assign cout_c  = lg[LEVELS][WIDTH-1];
  assign ovf_c   = lg[LEVELS][WIDTH-1] ^ lg[LEVELS][WIDTH-2];

  assign lr[LEVELS] = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (flush)           out_valid <= 1'b0;
      else if (lr[LEVELS]) out_valid <= lv[LEVELS];
      if (lr[LEVELS]) begin
        sum     <= sum_c;
        cout    <= cout_c;
        ovf     <= ovf_c;
        out_tag <= ltag[LEVELS];
      end
    end
  end

endmodule
